// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALUOp, funct and ALU Funct codes plus the buffered entry type.
package alu_ctrl_pkg;
  localparam logic [1:0] R_TYPE = 2'b10;
  localparam logic [1:0] I_SUB = 2'b00;
  localparam logic [1:0] I_ADD = 2'b01;
  localparam logic [1:0] I_AND = 2'b11;
  localparam logic [5:0] FN_ADDU = 6'b001011;
  localparam logic [5:0] FN_SUBU = 6'b001101;
  localparam logic [5:0] FN_AND = 6'b010010;
  localparam logic [5:0] FN_SLL = 6'b100110;
  localparam logic [5:0] ALU_NOP = 6'b000000;
  localparam logic [5:0] ALU_ADDU = 6'b001001;
  localparam logic [5:0] ALU_SUBU = 6'b001010;
  localparam logic [5:0] ALU_AND = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100001;
  typedef struct packed {
    logic [5:0] funct;
    logic illegal;
  } alu_ctrl_entry_t;
endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: valid/ready op bus into and out of the ALU control stage.
interface alu_ctrl_pipe_if #(parameter int TAG_W = 5);
  logic in_valid;
  logic in_ready;
  logic [5:0] in_funct;
  logic [1:0] in_alu_op;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [5:0] out_funct;
  logic out_illegal;
  logic [TAG_W-1:0] out_tag;
  modport master (output in_valid, in_funct, in_alu_op, in_tag, out_ready,
                  input in_ready, out_valid, out_funct, out_illegal, out_tag);
  modport slave (input in_valid, in_funct, in_alu_op, in_tag, out_ready,
                 output in_ready, out_valid, out_funct, out_illegal, out_tag);
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational funct/ALUOp to ALU Funct decoder with illegal flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] alu_op,
  output logic [5:0] funct_out,
  output logic       illegal
);
  assign funct_out = alu_op == I_SUB ? ALU_SUBU :
                     alu_op == I_ADD ? ALU_ADDU :
                     alu_op == I_AND ? ALU_AND  :
                     funct == FN_ADDU ? ALU_ADDU :
                     funct == FN_SUBU ? ALU_SUBU :
                     funct == FN_AND  ? ALU_AND  :
                     funct == FN_SLL  ? ALU_SLL  : ALU_NOP;
  // only R-type can miss; every recognised R-type code maps to a nonzero Funct
  assign illegal = alu_op == R_TYPE && funct_out == ALU_NOP;
endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: decoded ALU control behind a 2-entry elastic buffer with illegal-op counter.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  alu_ctrl_pipe_if.slave   bus,
  output logic [CNT_W-1:0] illegal_cnt
);
  alu_ctrl_entry_t dec;
  alu_ctrl_entry_t ent_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0] cnt;
  logic wp, rp, push, pop;
  alu_ctrl_decode u_dec (
    .funct(bus.in_funct),
    .alu_op(bus.in_alu_op),
    .funct_out(dec.funct),
    .illegal(dec.illegal)
  );
  assign bus.in_ready = !rst && !flush && cnt != 2'd2;
  assign bus.out_valid = cnt != 2'd0;
  assign bus.out_funct = ent_q[rp].funct;
  assign bus.out_illegal = ent_q[rp].illegal;
  assign bus.out_tag = tag_q[rp];
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      ent_q <= '{default: '0};
      tag_q <= '{default: '0};
      illegal_cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (push) begin
        ent_q[wp] <= dec;
        tag_q[wp] <= bus.in_tag;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
      if (push && dec.illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_alu_ctrl_pipe;
  localparam int TAG_W = 5;
  localparam int CNT_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [CNT_W-1:0] illegal_cnt;
  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] sb [$];
  logic [11:0] exp_e;
  logic [5:0] fi [7] = '{6'b001011, 6'b001101, 6'b010010, 6'b100110, 6'b111111, 6'b000000, 6'b001011};
  logic [1:0] ao [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [5:0] fo [7] = '{6'b001001, 6'b001010, 6'b010001, 6'b100001, 6'b001010, 6'b001001, 6'b010001};
  alu_ctrl_pipe_if #(.TAG_W(TAG_W)) bus ();
  alu_ctrl_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .illegal_cnt(illegal_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [5:0] f, input logic [1:0] a, input logic [4:0] t, input logic [5:0] ef, input logic ei);
    bus.in_valid = 1'b1;
    bus.in_funct = f;
    bus.in_alu_op = a;
    bus.in_tag = t;
    exp_e = {ef, ei, t};
  endtask
  task automatic wait_acc();
    int b = 0;
    while (!bus.in_ready && b < 50) begin
      tick();
      b++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    tick();
  endtask
  task automatic send_op(input int i, input logic [4:0] t);
    drive(fi[i], ao[i], t, fo[i], 1'b0);
    wait_acc();
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_output", {20'h0, bus.out_funct, bus.out_illegal, bus.out_tag}, 32'hffff_ffff);
      else check("scoreboard", {20'h0, bus.out_funct, bus.out_illegal, bus.out_tag}, {20'h0, sb.pop_front()});
    end
    if (rst || flush) sb.delete();
    else if (bus.in_valid && bus.in_ready) sb.push_back(exp_e);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_funct = '0;
    bus.in_alu_op = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    exp_e = '0;
    repeat (2) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_funct", bus.out_funct, 0);
    check("rst_out_illegal", bus.out_illegal, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_op(i, 5'(i + 1));
      bus.in_valid = 1'b0;
      check("latency_valid", bus.out_valid, 1);
      check("latency_funct", bus.out_funct, fo[i]);
      tick();
    end
    drive(6'b000111, 2'b10, 5'd7, 6'b000000, 1'b1);
    wait_acc();
    bus.in_valid = 1'b0;
    check("ill_valid", bus.out_valid, 1);
    check("ill_funct", bus.out_funct, 0);
    check("ill_flag", bus.out_illegal, 1);
    check("ill_tag", bus.out_tag, 7);
    check("ill_cnt_1", illegal_cnt, 1);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      check("stream_in_ready", bus.in_ready, 1);
      send_op(i % 7, 5'(i + 10));
    end
    idle(3);
    check("stream_drained", sb.size(), 0);
    bus.out_ready = 1'b0;
    drive(fi[0], ao[0], 5'd20, fo[0], 1'b0);
    tick();
    drive(fi[1], ao[1], 5'd21, fo[1], 1'b0);
    tick();
    check("bp_in_ready_full", bus.in_ready, 0);
    check("bp_head_funct", bus.out_funct, fo[0]);
    drive(fi[3], ao[3], 5'd22, fo[3], 1'b0);
    tick();
    check("bp_in_ready_held", bus.in_ready, 0);
    check("bp_stable_funct", bus.out_funct, fo[0]);
    check("bp_stable_tag", bus.out_tag, 20);
    check("bp_sb_two", sb.size(), 2);
    bus.out_ready = 1'b1;
    wait_acc();
    idle(4);
    check("bp_drained", sb.size(), 0);
    bus.out_ready = 1'b0;
    send_op(2, 5'd1);
    send_op(5, 5'd2);
    drive(6'b000111, 2'b10, 5'd3, 6'b000000, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready_after", bus.in_ready, 1);
    check("flush_cnt_kept", illegal_cnt, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(6'b111000, 2'b10, 5'(i), 6'b000000, 1'b1);
      wait_acc();
    end
    bus.in_valid = 1'b0;
    check("sat_cnt", illegal_cnt, 3);
    drive(6'b000111, 2'b10, 5'd9, 6'b000000, 1'b1);
    wait_acc();
    bus.in_valid = 1'b0;
    check("sat_hold", illegal_cnt, 3);
    idle(2);
    bus.out_ready = 1'b0;
    send_op(3, 5'd17);
    drive(fi[1], ao[1], 5'd18, fo[1], 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 0);
    tick();
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_funct", bus.out_funct, 0);
    check("rst_mid_illegal", bus.out_illegal, 0);
    check("rst_mid_tag", bus.out_tag, 0);
    check("rst_mid_cnt", illegal_cnt, 0);
    check("rst_mid_in_ready_hold", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_release", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    send_op(6, 5'd30);
    bus.in_valid = 1'b0;
    idle(3);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
